serial_tx: RTL and testbench
============================

Name: serial_tx

Overview:
- Parallel-in, serial-out transmitter; the send end of the single-bit serial link whose receive end is a chain of D flip-flops clocked by the same clk.
- Accepts a WIDTH-bit word through a valid/ready handshake, then drives it onto tx_bit one bit per clock, LSB first, with frame and last-bit markers.
- Supports gapless back-to-back frames.

Parameters:
WIDTH  8  data word width in bits; legal range 2..32

Ports:
clk  input  1  rising-edge clock
clear  input  1  synchronous reset, active-high
load_valid  input  1  data_in holds a word to send
load_ready  output  1  transmitter can accept a word this cycle
data_in  input  WIDTH  parallel word; sampled only at accept
tx_bit  output  1  serial data bit, LSB first
tx_frame  output  1  high while tx_bit carries a valid frame bit
tx_last  output  1  high during the final bit of a frame

Behaviour:
- Accept: a rising edge where load_valid=1 and load_ready=1. data_in is latched into the shift register; the bit counter loads 0; a frame starts.
- Without load_ready, load_valid is ignored. There is no buffering, and data_in is never sampled outside an accept.
- States:
  - IDLE: tx_frame=0, tx_bit=0, tx_last=0, load_ready=1.
  - SHIFT: one cycle per data bit.
  - PAR: exists only with the optional feature.
- Timing: the first bit appears in the cycle after the accept edge. Cycle k after accept (k=1..WIDTH) presents tx_bit=data_in[k-1] and tx_frame=1.
- Shift/count: the shift register shifts right one position per cycle. The counter increments per cycle and needs width sufficient for WIDTH+1.
- tx_last=1 exactly in the final frame cycle: counter = WIDTH-1 in SHIFT, or the PAR cycle when present.
- load_ready = IDLE or tx_last. An accept in the tx_last cycle starts the next frame the following cycle, with tx_frame staying high and no gap.
- Frame end with no accept: return to IDLE. tx_frame and tx_bit drop to 0 the next cycle.
- tx_bit is forced to 0 whenever tx_frame=0.
- All outputs derive from registered state; no combinational path from data_in to tx_bit.
- clear=1 at a rising edge, from any state including mid-frame:
  - state goes to IDLE; shift register, counter and parity register go to 0.
  - the next cycle shows tx_frame=0, tx_bit=0, tx_last=0, load_ready=1.
  - an aborted frame is not resumed.
- clear takes priority over a simultaneous accept; the word is dropped.

Optional Feature:
Macro: SERIAL_TX_PARITY_EN
- Defined:
  - at accept, the even-parity bit (XOR of all data_in bits) is stored.
  - after the WIDTH data cycles, one PAR cycle drives tx_bit = stored parity with tx_frame=1.
  - tx_last moves from the last data cycle to the PAR cycle; frame length is WIDTH+1.
  - load_ready is high in the PAR cycle (its tx_last cycle), allowing a gapless next frame.
- Undefined: no PAR state, no parity register; frame length is WIDTH.

Test Plan:
- Reset: clear=1 for 2 cycles with load_valid=1, data_in=8'hFF -> tx_frame=0, tx_bit=0, tx_last=0, load_ready=1; no frame starts.
- Single frame 8'hA5 accepted at edge 0 -> cycles 1..8 tx_bit=1,0,1,0,0,1,0,1; tx_frame=1 in cycles 1..8; tx_last=1 only in cycle 8; cycle 9 tx_frame=0.
- Back-to-back: load_valid held, 8'h01 then 8'hFF; second word accepted at the tx_last edge (cycle 8) -> tx_frame high for 16 consecutive cycles; tx_bit=1,0,0,0,0,0,0,0 then eight 1s.
- Ignored load: during a frame carrying 8'hC3, pulse load_valid with 8'h00 in cycle 4 (load_ready=0) -> serial output unchanged (1,1,0,0,0,0,1,1); no extra frame.
- Mid-frame clear: clear=1 at cycle 3 of 8'hFF -> cycle 4 tx_frame=0, tx_bit=0, load_ready=1; next accept of 8'h80 produces seven 0s then 1, tx_last on the 8th bit.
- With SERIAL_TX_PARITY_EN: 8'h07 -> 9-cycle frame: 1,1,1,0,0,0,0,0 then parity 1; tx_last in cycle 9; 8'h03 -> parity bit 0.

Source files
------------

// File: rtl/serial_tx.sv
// Parallel-in, serial-out transmitter: valid/ready word load, LSB-first bit stream with frame/last markers.
// Optional even-parity trailer bit enabled by defining SERIAL_TX_PARITY_EN.
module serial_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             tx_bit,
  output logic             tx_frame,
  output logic             tx_last
);

  localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last_data;

`ifdef SERIAL_TX_PARITY_EN
  logic             par;

  function automatic logic even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction
`endif

  assign accept    = load_valid & load_ready;
  assign last_data = (state == SHIFT) && (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (last_data) begin
`ifdef SERIAL_TX_PARITY_EN
          state_nxt = PAR;
`else
          state_nxt = accept ? SHIFT : IDLE;
`endif
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PAR: begin
        state_nxt = accept ? SHIFT : IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: an accept always reloads, otherwise shift only while in SHIFT.
  always_ff @(posedge clk) begin
    if (clear) begin
      shreg <= '0;
      cnt   <= '0;
`ifdef SERIAL_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else if (accept) begin
      shreg <= data_in;
      cnt   <= '0;
`ifdef SERIAL_TX_PARITY_EN
      par   <= even_parity(data_in);
`endif
    end else if (state == SHIFT) begin
      shreg <= shreg >> 1;
      cnt   <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    tx_frame   = 1'b0;
    tx_bit     = 1'b0;
    tx_last    = 1'b0;
    load_ready = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
      end
      SHIFT: begin
        tx_frame = 1'b1;
        tx_bit   = shreg[0];
`ifndef SERIAL_TX_PARITY_EN
        tx_last    = last_data;
        load_ready = last_data;
`endif
      end
`ifdef SERIAL_TX_PARITY_EN
      PAR: begin
        tx_frame   = 1'b1;
        tx_bit     = par;
        tx_last    = 1'b1;
        load_ready = 1'b1;
      end
`endif
      default: begin
        load_ready = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: stimulus pushes expected serial bits, a negedge monitor pops and compares.
// Expected bit streams are written in emission order (leftmost character = first bit on the wire).
module tb_serial_tx;

  logic       clk = 1'b0;
  logic       clear;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] data_in;
  logic       tx_bit;
  logic       tx_frame;
  logic       tx_last;

`ifdef SERIAL_TX_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  int         n_cmp = 0;
  int         n_bad = 0;
  logic       mon_en = 1'b0;
  logic [1:0] exp_q[$];

  serial_tx #(.WIDTH(8)) dut (
    .clk        (clk),
    .clear      (clear),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .data_in    (data_in),
    .tx_bit     (tx_bit),
    .tx_frame   (tx_frame),
    .tx_last    (tx_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // seq: emission order, seq[7] goes out first; par used only when the parity trailer exists
  task automatic push_seq(input logic [7:0] seq, input logic par);
    for (int i = 7; i >= 0; i--)
      exp_q.push_back({seq[i], (i == 0) && (FL == 8)});
`ifdef SERIAL_TX_PARITY_EN
    exp_q.push_back({par, 1'b1});
`endif
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (tx_frame) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_frame_bit: tx_frame=1 tx_bit=%0b, expected no frame at %0t", tx_bit, $time);
        end else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          chk("tx_bit", tx_bit, e[1]);
          chk("tx_last", tx_last, e[0]);
        end
      end else begin
        chk("idle_tx_bit", tx_bit, 0);
        chk("idle_tx_last", tx_last, 0);
      end
    end
  end

  initial begin
    clear = 1'b1;
    load_valid = 1'b1;
    data_in = 8'hFF;
    tick();
    tick();
    chk("rst_frame", tx_frame, 0);
    chk("rst_bit", tx_bit, 0);
    chk("rst_last", tx_last, 0);
    chk("rst_ready", load_ready, 1);
    clear = 1'b0;
    load_valid = 1'b0;
    mon_en = 1'b1;
    tick();
    chk("rst_no_frame", tx_frame, 0);

    // Single frame A5
    load_valid = 1'b1;
    data_in = 8'hA5;
    push_seq(8'b10100101, 1'b0);
    tick();
    load_valid = 1'b0;
    data_in = 8'h00;
    chk("a5_ready_c1", load_ready, 0);
    chk("a5_frame_c1", tx_frame, 1);
    repeat (FL - 1) tick();
    chk("a5_last_final", tx_last, 1);
    chk("a5_ready_final", load_ready, 1);
    tick();
    chk("a5_frame_after", tx_frame, 0);
    tick();

    // Back-to-back 01 then FF, valid held until the second accept
    load_valid = 1'b1;
    data_in = 8'h01;
    push_seq(8'b10000000, 1'b1);
    tick();
    data_in = 8'hFF;
    push_seq(8'b11111111, 1'b0);
    for (int i = 1; i <= 2 * FL; i++) begin
      chk("b2b_frame", tx_frame, 1);
      tick();
      if (i == FL) load_valid = 1'b0;
    end
    chk("b2b_frame_end", tx_frame, 0);
    tick();

    // Ignored load during a frame carrying C3
    load_valid = 1'b1;
    data_in = 8'hC3;
    push_seq(8'b11000011, 1'b0);
    tick();
    load_valid = 1'b0;
    repeat (3) tick();
    chk("ign_ready_c4", load_ready, 0);
    load_valid = 1'b1;
    data_in = 8'h00;
    tick();
    load_valid = 1'b0;
    repeat (FL - 4) tick();
    chk("ign_frame_end", tx_frame, 0);
    repeat (3) tick();
    chk("ign_no_extra", tx_frame, 0);

    // Mid-frame clear on FF, then 80
    load_valid = 1'b1;
    data_in = 8'hFF;
    repeat (3) exp_q.push_back(2'b10);
    tick();
    load_valid = 1'b0;
    repeat (2) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_frame", tx_frame, 0);
    chk("clr_bit", tx_bit, 0);
    chk("clr_last", tx_last, 0);
    chk("clr_ready", load_ready, 1);
    tick();
    chk("clr_no_resume", tx_frame, 0);
    load_valid = 1'b1;
    data_in = 8'h80;
    push_seq(8'b00000001, 1'b1);
    tick();
    load_valid = 1'b0;
    repeat (FL - 1) tick();
    chk("x80_last_final", tx_last, 1);
    tick();
    chk("x80_frame_after", tx_frame, 0);

`ifdef SERIAL_TX_PARITY_EN
    // Parity trailer: 07 -> 1, 03 -> 0, sent gapless
    load_valid = 1'b1;
    data_in = 8'h07;
    push_seq(8'b11100000, 1'b1);
    tick();
    data_in = 8'h03;
    push_seq(8'b11000000, 1'b0);
    repeat (FL - 2) tick();
    chk("par_last_c8", tx_last, 0);
    chk("par_ready_c8", load_ready, 0);
    tick();
    chk("par_last_c9", tx_last, 1);
    chk("par_ready_c9", load_ready, 1);
    tick();
    load_valid = 1'b0;
    chk("par_gapless", tx_frame, 1);
    repeat (FL) tick();
    chk("par_frame_end", tx_frame, 0);
`endif

    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk("queue_drained", exp_q.size(), 0);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
